// File: rtl/demux_1x5_tdm.sv
// Registered 1-to-5 TDM demultiplexer with manual-select and auto frame-scan modes.
// Optional build macro DEMUX_1X5_PARITY_EN adds a sixth even-parity slot per auto frame.
module demux_1x5_tdm #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             auto_mode,
   input  logic [2:0]       sel,
   input  logic             frame_start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [2:0]       slot_idx,
   output logic             frame_done,
   output logic             sel_err,
   output logic             parity_err
);

`ifdef DEMUX_1X5_PARITY_EN
   localparam logic [2:0] LAST = 3'd5;
`else
   localparam logic [2:0] LAST = 3'd4;
`endif

   logic [WIDTH-1:0] shadow_q [5];
   logic [WIDTH-1:0] shadow_d [5];
   logic [WIDTH-1:0] out_q    [5];
   logic [WIDTH-1:0] out_d    [5];
   logic [2:0]       slot_q, slot_d;
   logic             done_q, done_d;
   logic             serr_q, serr_d;
   logic             perr_q, perr_d;
   logic [2:0]       wr_idx;

   always_comb begin
      shadow_d = shadow_q;
      out_d    = out_q;
      slot_d   = slot_q;
      done_d   = 1'b0;
      serr_d   = 1'b0;
      perr_d   = 1'b0;
      // frame_start realigns to slot 0, discarding whatever partial frame was in flight
      wr_idx   = frame_start ? 3'd0 : slot_q;

      if (!auto_mode) begin
         slot_d = 3'd0;
         if (din_valid) begin
            if (sel <= 3'd4) out_d[sel] = din;
            else             serr_d     = 1'b1;
         end
      end else if (din_valid) begin
         if (wr_idx == LAST) begin
            for (int i = 0; i < 5; i++) out_d[i] = shadow_q[i];
`ifdef DEMUX_1X5_PARITY_EN
            perr_d = |(shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3] ^ shadow_q[4] ^ din);
`else
            // final data word bypasses the shadow so the load is still atomic
            out_d[4] = din;
`endif
            done_d = 1'b1;
            slot_d = 3'd0;
         end else begin
            shadow_d[wr_idx] = din;
            slot_d           = wr_idx + 3'd1;
         end
      end else if (frame_start) begin
         slot_d = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) begin
            shadow_q[i] <= '0;
            out_q[i]    <= '0;
         end
         slot_q <= 3'd0;
         done_q <= 1'b0;
         serr_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         out_q    <= out_d;
         slot_q   <= slot_d;
         done_q   <= done_d;
         serr_q   <= serr_d;
         perr_q   <= perr_d;
      end
   end

   assign a          = out_q[0];
   assign b          = out_q[1];
   assign c          = out_q[2];
   assign d          = out_q[3];
   assign e          = out_q[4];
   assign slot_idx   = slot_q;
   assign frame_done = done_q;
   assign sel_err    = serr_q;
   assign parity_err = perr_q;

endmodule

// File: tb/tb_demux_1x5_tdm.sv
// Self-checking bench for demux_1x5_tdm: vector table, directed frame sequences and random
// stimulus against a queue-based frame model.
module tb_demux_1x5_tdm;
   localparam int W = 4;
`ifdef DEMUX_1X5_PARITY_EN
   localparam int NS = 6;
`else
   localparam int NS = 5;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  din = '0;
   logic          din_valid = 1'b0, auto_mode = 1'b0, frame_start = 1'b0;
   logic [2:0]    sel = 3'd0;
   logic [W-1:0]  a, b, c, d, e;
   logic [2:0]    slot_idx;
   logic          frame_done, sel_err, parity_err;

   demux_1x5_tdm #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .auto_mode(auto_mode),
      .sel(sel), .frame_start(frame_start), .a(a), .b(b), .c(c), .d(d), .e(e),
      .slot_idx(slot_idx), .frame_done(frame_done), .sel_err(sel_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, fd_cnt = 0;

   // reference model: words of the frame in flight plus the five visible channels
   logic [W-1:0] m_out [5];
   logic [W-1:0] m_q   [$];
   logic         m_fd, m_se, m_pe;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_out[i] = '0;
      m_q.delete();
      m_fd = 0; m_se = 0; m_pe = 0;
   endtask

   task automatic model_edge(input logic v, am, fs, input logic [2:0] s, input logic [W-1:0] dd);
      logic [W-1:0] x;
      m_fd = 0; m_se = 0; m_pe = 0;
      if (!am) begin
         m_q.delete();
         if (v) begin
            if (s < 5) m_out[s] = dd;
            else       m_se = 1;
         end
      end else begin
         if (fs) m_q.delete();
         if (v) begin
            m_q.push_back(dd);
            if (m_q.size() == NS) begin
               x = '0;
               for (int i = 0; i < NS; i++) x ^= m_q[i];
               for (int i = 0; i < 5; i++) m_out[i] = m_q[i];
               if (NS == 6) m_pe = |x;
               m_fd = 1;
               m_q.delete();
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".a"}, 32'(a), 32'(m_out[0]));
      chk({tag, ".b"}, 32'(b), 32'(m_out[1]));
      chk({tag, ".c"}, 32'(c), 32'(m_out[2]));
      chk({tag, ".d"}, 32'(d), 32'(m_out[3]));
      chk({tag, ".e"}, 32'(e), 32'(m_out[4]));
      chk({tag, ".slot_idx"}, 32'(slot_idx), 32'(m_q.size()));
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
      chk({tag, ".sel_err"}, 32'(sel_err), 32'(m_se));
      chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_pe));
   endtask

   task automatic step(input string tag, input logic v, am, fs, input logic [2:0] s,
                       input logic [W-1:0] dd);
      din_valid = v; auto_mode = am; frame_start = fs; sel = s; din = dd;
      @(posedge clk);
      model_edge(v, am, fs, s, dd);
      #1;
      if (frame_done) fd_cnt++;
      compare_all(tag);
   endtask

   function automatic logic [W-1:0] xor5(input logic [W-1:0] w [5]);
      return w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4];
   endfunction

   typedef struct {
      logic            v;
      logic [2:0]      s;
      logic [W-1:0]    dd;
      logic [4:0][W-1:0] exp;   // index 0 = a
      logic            se;
   } mvec_t;

   mvec_t tbl [8];
   logic [W-1:0] wds [8];
   logic [W-1:0] t3 [5];

   initial begin
      tbl[0] = '{1'b1, 3'd0, 4'd1, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1}, 1'b0};
      tbl[1] = '{1'b1, 3'd1, 4'd1, {4'd0, 4'd0, 4'd0, 4'd1, 4'd1}, 1'b0};
      tbl[2] = '{1'b1, 3'd2, 4'd1, {4'd0, 4'd0, 4'd1, 4'd1, 4'd1}, 1'b0};
      tbl[3] = '{1'b1, 3'd3, 4'd1, {4'd0, 4'd1, 4'd1, 4'd1, 4'd1}, 1'b0};
      tbl[4] = '{1'b1, 3'd4, 4'd1, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, 1'b0};
      tbl[5] = '{1'b1, 3'd5, 4'd0, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, 1'b1};
      tbl[6] = '{1'b1, 3'd6, 4'd0, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, 1'b1};
      tbl[7] = '{1'b1, 3'd7, 4'd0, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, 1'b1};

      // T1: reset state
      model_reset();
      #3;
      compare_all("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compare_all("reset_release");

      // T2: manual routing from the vector table
      for (int k = 0; k < 8; k++) begin
         step("manual", tbl[k].v, 1'b0, 1'b0, tbl[k].s, tbl[k].dd);
         chk("tbl.outs", 32'({e, d, c, b, a}), 32'(tbl[k].exp));
         chk("tbl.sel_err", 32'(sel_err), 32'(tbl[k].se));
      end
      step("manual_idle", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

      // T1 (async): reset asserted mid-cycle clears outputs before any edge
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_reset");
      #2;
      rst_n = 1'b1;

      // T3: one auto frame; a..e stay 0 until the frame completes
      t3 = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
      fd_cnt = 0;
      for (int i = 0; i < 5; i++) step("t3", 1'b1, 1'b1, 1'b0, 3'd0, t3[i]);
`ifdef DEMUX_1X5_PARITY_EN
      step("t3_par", 1'b1, 1'b1, 1'b0, 3'd0, xor5(t3));
`endif
      chk("t3.outs", 32'({e, d, c, b, a}), 32'({4'd0, 4'd1, 4'd1, 4'd0, 4'd1}));
      chk("t3.frame_done", 32'(frame_done), 32'd1);
      step("t3_idle", 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);

      // T4: partial frame, stall, then realign with frame_start
      fd_cnt = 0;
      for (int i = 0; i < 8; i++) wds[i] = W'($urandom);
      for (int i = 0; i < 3; i++) step("t4_part", 1'b1, 1'b1, 1'b0, 3'd0, wds[i]);
      step("t4_stall", 1'b0, 1'b1, 1'b0, 3'd0, 4'hf);
      step("t4_stall", 1'b0, 1'b1, 1'b0, 3'd0, 4'hf);
      step("t4_fs", 1'b1, 1'b1, 1'b1, 3'd0, wds[3]);
      for (int i = 4; i < 8; i++) step("t4_rest", 1'b1, 1'b1, 1'b0, 3'd0, wds[i]);
`ifdef DEMUX_1X5_PARITY_EN
      step("t4_par", 1'b1, 1'b1, 1'b0, 3'd0, wds[3]^wds[4]^wds[5]^wds[6]^wds[7]);
`endif
      step("t4_idle", 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
      chk("t4.frame_done_count", 32'(fd_cnt), 32'd1);
      chk("t4.outs", 32'({e, d, c, b, a}), 32'({wds[7], wds[6], wds[5], wds[4], wds[3]}));

      // T5: three back-to-back frames
      fd_cnt = 0;
      for (int i = 0; i < 3 * NS; i++) step("t5", 1'b1, 1'b1, 1'b0, 3'd0, W'($urandom));
      chk("t5.frame_done_count", 32'(fd_cnt), 32'd3);

`ifdef DEMUX_1X5_PARITY_EN
      // T6: good and bad parity
      for (int i = 0; i < 5; i++) step("t6_ok", 1'b1, 1'b1, 1'b0, 3'd0, t3[i]);
      step("t6_ok_par", 1'b1, 1'b1, 1'b0, 3'd0, 4'd1);
      chk("t6.parity_ok", 32'(parity_err), 32'd0);
      for (int i = 0; i < 5; i++) step("t6_bad", 1'b1, 1'b1, 1'b0, 3'd0, t3[i]);
      step("t6_bad_par", 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
      chk("t6.parity_bad", 32'(parity_err), 32'd1);
      chk("t6.outs", 32'({e, d, c, b, a}), 32'({4'd0, 4'd1, 4'd1, 4'd0, 4'd1}));
`endif

      // mode switch mid-frame drops the partial frame
      step("sw_a", 1'b1, 1'b1, 1'b0, 3'd0, 4'h7);
      step("sw_b", 1'b1, 1'b1, 1'b0, 3'd0, 4'h8);
      step("sw_man", 1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
      step("sw_back", 1'b1, 1'b1, 1'b0, 3'd0, 4'h9);

      // random stimulus against the model
      for (int i = 0; i < 600; i++) begin
         step("rand",
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) != 0,
              $urandom_range(0, 19) == 0,
              3'($urandom_range(0, 7)),
              W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
